// File: rtl/mem_arbiter.sv
// Arbiter for the shared single-port I/D memory. LS wins from idle, grants alternate
// while both requesters stay busy, and reads wait out MEM_LAT before the ack pulse.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_LS   = 1'b1;
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic          own_q, own_d;
    logic          we_q, we_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          grant_if, grant_ls;

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        case (state_q)
            IDLE: begin
                if (ls_req)      grant_ls = 1'b1;
                else if (if_req) grant_if = 1'b1;
            end
            ISSUE: begin
                // Stores need no read data, so they skip the latency wait.
                if (we_q || MEM_LAT == 1) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RESP;
            end
            RESP: begin
                // The owner's req is still high here; only the other side may win.
                if (own_q == OWN_IF && ls_req)      grant_ls = 1'b1;
                else if (own_q == OWN_LS && if_req) grant_if = 1'b1;
                else                                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (grant_ls) begin
            state_d = ISSUE;
            own_d   = OWN_LS;
            we_d    = ls_we;
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
        end else if (grant_if) begin
            state_d = ISSUE;
            own_d   = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= OWN_IF;
            we_q    <= 1'b0;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign if_ack    = (state_q == RESP) && (own_q == OWN_IF);
    assign ls_ack    = (state_q == RESP) && (own_q == OWN_LS);
    assign if_rdata  = if_ack ? mem_rdata : '0;
    assign ls_rdata  = (ls_ack && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 3, 4) each with its own memory model;
// vector table, directed corner sequences, then random traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 3;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic clk = 1'b0;
    logic rst, minit;
    logic          if_req [N];
    logic [AW-1:0] if_addr [N];
    logic          if_ack [N];
    logic [DW-1:0] if_rdata [N];
    logic          ls_req [N];
    logic          ls_we [N];
    logic [AW-1:0] ls_addr [N];
    logic [DW-1:0] ls_wdata [N];
    logic          ls_ack [N];
    logic [DW-1:0] ls_rdata [N];
    logic          mem_en [N];
    logic          mem_we [N];
    logic [AW-1:0] mem_addr [N];
    logic [DW-1:0] mem_wdata [N];
    logic [DW-1:0] mem_rdata [N];
    logic          busy [N];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] finit(input int w);
        return 32'hDEADBEEF ^ ((w - 4) * 32'h00010001);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        logic [31:0] mem [256];
        logic [31:0] pipe [L];

        mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_addr(ls_addr[g]), .ls_wdata(ls_wdata[g]),
            .ls_ack(ls_ack[g]), .ls_rdata(ls_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        // Read data appears exactly L cycles after the strobe; any other cycle shows a poison word.
        always @(posedge clk) begin
            if (minit) begin
                for (int i = 0; i < 256; i++) mem[i] <= finit(i);
            end else if (mem_en[g] && mem_we[g]) begin
                mem[mem_addr[g][9:2]] <= mem_wdata[g];
            end
            pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][9:2]] : 32'hBAD0BAD0;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[L-1];
    end

    task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) begin
            if_req[k] = 1'b0; if_addr[k] = Z;
            ls_req[k] = 1'b0; ls_we[k] = 1'b0; ls_addr[k] = Z; ls_wdata[k] = Z;
        end
    endtask

    typedef struct {
        logic ir; logic [31:0] ia;
        logic lr; logic lw; logic [31:0] la; logic [31:0] ld;
        logic e_en; logic e_we; logic [31:0] e_addr; logic [31:0] e_wd;
        logic e_iack; logic e_lack; logic [31:0] e_ird; logic [31:0] e_lrd; logic e_busy;
    } vec_t;

    function automatic vec_t mv(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                                input logic [31:0] la, input logic [31:0] ld, input logic en, input logic we,
                                input logic [31:0] ad, input logic [31:0] wd, input logic iack, input logic lack,
                                input logic [31:0] ird, input logic [31:0] lrd, input logic bz);
        vec_t v;
        v.ir = ir; v.ia = ia; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
        v.e_en = en; v.e_we = we; v.e_addr = ad; v.e_wd = wd;
        v.e_iack = iack; v.e_lack = lack; v.e_ird = ird; v.e_lrd = lrd; v.e_busy = bz;
        return v;
    endfunction

    vec_t tv[$];
    logic [31:0] rmem [N][256];
    logic act [N][2];
    logic iss [N][2];
    logic rwe [N][2];
    logic [31:0] ra [N][2];
    logic [31:0] rwd [N][2];
    int age [N][2];
    int icyc [N][2];
    logic prev_own [N];
    int prev_ack [N];
    int cyc, n_en, ncand, want;
    logic ackd [2];
    logic seen, store;
    logic [31:0] expd, gotd;
    logic [5:0] ord;
    logic q_who[$];
    int q_at[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; minit = 1'b1;
        idle_all();
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++)
            chk($sformatf("reset_k%0d", k),
                {if_ack[k], ls_ack[k], if_rdata[k], ls_rdata[k], mem_en[k], mem_we[k],
                 mem_addr[k], mem_wdata[k], busy[k]}, 160'd0);
        rst = 1'b0; minit = 1'b0;
        @(negedge clk);

        // ---- vector table, MEM_LAT=1 ----
        tv.push_back(mv(T,32'h10, F,F,Z,Z, F,F,Z,Z, F,F,Z,Z, F));
        tv.push_back(mv(T,32'h10, F,F,Z,Z, T,F,32'h10,Z, F,F,Z,Z, T));
        tv.push_back(mv(F,32'h10, F,F,Z,Z, F,F,Z,Z, T,F,32'hDEADBEEF,Z, T));
        tv.push_back(mv(F,Z, F,F,Z,Z, F,F,Z,Z, F,F,Z,Z, F));
        tv.push_back(mv(T,32'h10, F,F,Z,Z, F,F,Z,Z, F,F,Z,Z, F));
        tv.push_back(mv(T,32'h14, F,F,Z,Z, T,F,32'h10,Z, F,F,Z,Z, T));
        tv.push_back(mv(F,32'h14, F,F,Z,Z, F,F,Z,Z, T,F,32'hDEADBEEF,Z, T));
        tv.push_back(mv(F,Z, F,F,Z,Z, F,F,Z,Z, F,F,Z,Z, F));
        tv.push_back(mv(T,32'h10, T,F,32'h20,Z, F,F,Z,Z, F,F,Z,Z, F));
        tv.push_back(mv(T,32'h10, T,F,32'h20,Z, T,F,32'h20,Z, F,F,Z,Z, T));
        tv.push_back(mv(T,32'h10, F,F,32'h20,Z, F,F,Z,Z, F,T,Z,32'hDEA9BEEB, T));
        tv.push_back(mv(T,32'h10, F,F,Z,Z, T,F,32'h10,Z, F,F,Z,Z, T));
        tv.push_back(mv(F,32'h10, F,F,Z,Z, F,F,Z,Z, T,F,32'hDEADBEEF,Z, T));
        tv.push_back(mv(F,Z, F,F,Z,Z, F,F,Z,Z, F,F,Z,Z, F));
        tv.push_back(mv(F,Z, T,T,32'h24,32'h77, F,F,Z,Z, F,F,Z,Z, F));
        tv.push_back(mv(F,Z, T,T,32'h24,32'h77, T,T,32'h24,32'h77, F,F,Z,Z, T));
        tv.push_back(mv(F,Z, F,T,32'h24,32'h77, F,F,Z,Z, F,T,Z,Z, T));
        tv.push_back(mv(F,Z, T,F,32'h24,Z, F,F,Z,Z, F,F,Z,Z, F));
        tv.push_back(mv(F,Z, T,F,32'h24,Z, T,F,32'h24,Z, F,F,Z,Z, T));
        tv.push_back(mv(F,Z, F,F,32'h24,Z, F,F,Z,Z, F,T,Z,32'h77, T));
        tv.push_back(mv(F,Z, F,F,Z,Z, F,F,Z,Z, F,F,Z,Z, F));
        foreach (tv[i]) begin
            if_req[0] = tv[i].ir; if_addr[0] = tv[i].ia;
            ls_req[0] = tv[i].lr; ls_we[0] = tv[i].lw; ls_addr[0] = tv[i].la; ls_wdata[0] = tv[i].ld;
            #1;
            chk($sformatf("vec%0d", i),
                {mem_en[0], mem_we[0], if_ack[0], ls_ack[0], busy[0], if_rdata[0], ls_rdata[0],
                 tv[i].e_en ? mem_addr[0] : Z, tv[i].e_we ? mem_wdata[0] : Z},
                {tv[i].e_en, tv[i].e_we, tv[i].e_iack, tv[i].e_lack, tv[i].e_busy, tv[i].e_ird, tv[i].e_lrd,
                 tv[i].e_en ? tv[i].e_addr : Z, tv[i].e_we ? tv[i].e_wd : Z});
            @(negedge clk);
        end
        idle_all();
        @(negedge clk);

        // ---- MEM_LAT=3: store 0x55 to 0x40, then load it back ----
        ls_req[1] = 1'b1; ls_we[1] = 1'b1; ls_addr[1] = 32'h40; ls_wdata[1] = 32'h55;
        @(negedge clk);
        chk("st_issue", {mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1]}, {1'b1, 1'b1, 32'h40, 32'h55});
        @(negedge clk);
        chk("st_ack", {ls_ack[1], if_ack[1], ls_rdata[1]}, {1'b1, 1'b0, 32'h0});
        ls_req[1] = 1'b0;
        @(negedge clk);
        ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h40; ls_wdata[1] = Z;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("ld_lat_c%0d", c), {ls_ack[1], ls_rdata[1]},
                (c == 4) ? {1'b1, 32'h55} : {1'b0, 32'h0});
        end
        ls_req[1] = 1'b0;
        @(negedge clk);

        // ---- MEM_LAT=3: both held continuously, six transactions ----
        if_req[1] = 1'b1; if_addr[1] = 32'h10;
        ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h40;
        cyc = 0; n_en = 0;
        while (q_who.size() < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_en[1]) n_en++;
            if (ls_ack[1] || if_ack[1]) begin
                q_who.push_back(ls_ack[1]);
                q_at.push_back(cyc);
                chk($sformatf("alt_data%0d", q_who.size()),
                    ls_ack[1] ? {ls_ack[1], if_ack[1], ls_rdata[1]} : {ls_ack[1], if_ack[1], if_rdata[1]},
                    ls_ack[1] ? {1'b1, 1'b0, 32'h55} : {1'b0, 1'b1, 32'hDEADBEEF});
            end
        end
        if_req[1] = 1'b0; ls_req[1] = 1'b0;
        chk("alt_count", q_who.size(), 6);
        ord = 6'd0;
        foreach (q_who[i]) if (i < 6) ord[5-i] = q_who[i];
        chk("alt_order", ord, 6'b101010);
        foreach (q_at[i]) chk($sformatf("alt_time%0d", i), q_at[i], 4 * (i + 1));
        chk("alt_mem_en", n_en, 6);
        @(negedge clk);

        // ---- MEM_LAT=4: reset in mid-WAIT drops the fetch ----
        if_req[2] = 1'b1; if_addr[2] = 32'h10;
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", {busy[2], mem_en[2], if_ack[2]}, {1'b1, 1'b0, 1'b0});
        rst = 1'b1;
        #1;
        chk("rst_outputs",
            {if_ack[2], ls_ack[2], if_rdata[2], ls_rdata[2], mem_en[2], mem_we[2],
             mem_addr[2], mem_wdata[2], busy[2]}, 160'd0);
        if_req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | if_ack[2];
        end
        chk("rst_no_ack", seen, 1'b0);
        if_req[2] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("reissue_c%0d", c), {if_ack[2], if_rdata[2]},
                (c == 5) ? {1'b1, 32'hDEADBEEF} : {1'b0, 32'h0});
        end
        if_req[2] = 1'b0;
        @(negedge clk);

        // ---- random traffic on all three instances ----
        minit = 1'b1;
        @(negedge clk);
        minit = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 256; i++) rmem[k][i] = finit(i);
            for (int r = 0; r < 2; r++) begin
                act[k][r] = 1'b0; iss[k][r] = 1'b0; age[k][r] = 0; icyc[k][r] = 0;
            end
            prev_own[k] = 1'b0; prev_ack[k] = -10;
        end
        cyc = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < N; k++) begin
                ackd[0] = if_ack[k]; ackd[1] = ls_ack[k];
                chk($sformatf("quiet_k%0d", k),
                    {mem_we[k] & ~mem_en[k], if_ack[k] & ls_ack[k],
                     if_ack[k] ? Z : if_rdata[k], ls_ack[k] ? Z : ls_rdata[k]}, 160'd0);
                if (mem_en[k]) begin
                    ncand = int'(act[k][0] && !iss[k][0]) + int'(act[k][1] && !iss[k][1]);
                    if (ncand == 0) begin
                        chk($sformatf("issue_no_req_k%0d", k), mem_en[k], 1'b0);
                    end else begin
                        if (ncand == 2) want = (prev_ack[k] == cyc - 1) ? int'(!prev_own[k]) : 1;
                        else            want = (act[k][1] && !iss[k][1]) ? 1 : 0;
                        chk($sformatf("issue_k%0d", k),
                            {mem_we[k], mem_addr[k], mem_we[k] ? mem_wdata[k] : Z},
                            {(want == 1) && rwe[k][1], ra[k][want],
                             ((want == 1) && rwe[k][1]) ? rwd[k][1] : Z});
                        iss[k][want] = 1'b1;
                        icyc[k][want] = cyc;
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    if (ackd[r]) begin
                        if (!(act[k][r] && iss[k][r])) begin
                            chk($sformatf("spurious_ack_k%0d_r%0d", k, r), ackd[r], 1'b0);
                        end else begin
                            store = (r == 1) && rwe[k][1];
                            expd  = store ? Z : rmem[k][ra[k][r][9:2]];
                            gotd  = (r == 1) ? ls_rdata[k] : if_rdata[k];
                            chk($sformatf("ack_k%0d_r%0d", k, r), {gotd, cyc - icyc[k][r]},
                                {expd, store ? 1 : lat_of(k)});
                            if (store) rmem[k][ra[k][r][9:2]] = rwd[k][r];
                            act[k][r] = 1'b0; iss[k][r] = 1'b0;
                            prev_own[k] = (r == 1); prev_ack[k] = cyc;
                        end
                    end else if (act[k][r] && age[k][r] > 2 * lat_of(k) + 6) begin
                        chk($sformatf("timeout_k%0d_r%0d", k, r), act[k][r], 1'b0);
                        act[k][r] = 1'b0; iss[k][r] = 1'b0;
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    if (act[k][r]) begin
                        age[k][r]++;
                    end else if (!ackd[r] && t < 1950 && $urandom_range(0, 3) == 0) begin
                        act[k][r] = 1'b1; iss[k][r] = 1'b0; age[k][r] = 0;
                        if (r == 0) begin
                            ra[k][0] = {22'd0, 8'($urandom_range(0, 127)), 2'b00};
                            rwe[k][0] = 1'b0;
                        end else begin
                            ra[k][1] = {22'd0, 8'($urandom_range(128, 255)), 2'b00};
                            rwe[k][1] = 1'($urandom_range(0, 1));
                            rwd[k][1] = $urandom;
                        end
                    end
                end
                if_req[k] = act[k][0]; if_addr[k] = ra[k][0];
                ls_req[k] = act[k][1]; ls_we[k] = rwe[k][1];
                ls_addr[k] = ra[k][1]; ls_wdata[k] = rwd[k][1];
            end
        end
        for (int k = 0; k < N; k++)
            chk($sformatf("drain_k%0d", k), {act[k][0], act[k][1], busy[k]}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port unified instruction/data memory of the RISC `processor` between the instruction-fetch stage and the load/store stage. The block grants one requester at a time and sequences the memory command. It waits out the configured memory read latency and returns an acknowledge with read data to the granted requester. It sits between the pipeline front-end/LSU and the memory macro, inside `processor`.

## Interface
- `AW`, 32, address width in bits
- `DW`, 32, data width in bits
- `MEM_LAT`, 1, memory read latency in cycles (mem_en edge to mem_rdata valid); legal range 1..4

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch read request; held high until `if_ack`
- `if_addr`  in  AW  fetch address
- `if_ack`  out  1  one-cycle fetch completion pulse
- `if_rdata`  out  DW  fetch data; valid only while `if_ack`=1, else 0
- `ls_req`  in  1  load/store request; held high until `ls_ack`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_addr`  in  AW  load/store address
- `ls_wdata`  in  DW  store data
- `ls_ack`  out  1  one-cycle load/store completion pulse
- `ls_rdata`  out  DW  load data; valid only while `ls_ack`=1 on a load, else 0
- `mem_en`  out  1  memory command strobe (one cycle per transaction)
- `mem_we`  out  1  memory write enable; only ever high together with `mem_en`
- `mem_addr`  out  AW  memory address (registered)
- `mem_wdata`  out  DW  memory write data (registered)
- `mem_rdata`  in  DW  memory read data, valid MEM_LAT cycles after the `mem_en` edge
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Owner register `own` is 0 for fetch and 1 for LS.
- IDLE: if `ls_req`=1, set own=LS. Otherwise, if `if_req`=1, set own=IF. With no request, stay in IDLE. On a grant, latch address, write data and we into the mem_* registers and go to ISSUE. LS has priority over IF in IDLE.
- ISSUE: `mem_en`=1 for exactly this cycle, and `mem_we`=latched we.
  - Store: go to RESP.
  - Load/fetch with MEM_LAT=1: go to RESP.
  - Load/fetch with MEM_LAT>1: load the latency counter with MEM_LAT-1 and go to WAIT.
- WAIT: decrement the counter each cycle. Go to RESP when it reaches 1 (MEM_LAT-1 cycles spent in WAIT).
- RESP: assert the owner's ack. The owner's rdata is `mem_rdata` on reads and 0 on stores. Then arbitrate in the same cycle among requests, excluding the owner being acked (its req is still high this cycle):
  - If the other requester is pending, latch it and go to ISSUE.
  - Otherwise go to IDLE.
- When both requesters stay busy, grants alternate LS, IF, LS, …, so neither requester can starve.
- Address and data are captured only at grant. Input changes after grant are ignored. Dropping req before ack is a protocol violation; the transaction still completes and the ack is still pulsed.
- The non-owner's ack and rdata stay at 0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, own=0, counter=0. All outputs are 0: `if_ack`, `ls_ack`, `if_rdata`, `ls_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`.
- Read latency, req rise (cycle 0, IDLE) to ack: MEM_LAT+1 cycles. For MEM_LAT=1, ack is in cycle 2.
- Store latency: ack in cycle 2 regardless of MEM_LAT.
- Back-to-back transactions from RESP: the next `mem_en` comes 1 cycle after RESP, with no IDLE cycle in between.
- A requester sees its ack at a clock edge and must drop or change req in the following cycle. A new request from the same requester is served only after passing through IDLE or the other requester's transaction.
- Reset during ISSUE, WAIT or RESP drops the transaction: no ack is issued and `mem_en` goes low at once. A memory write already strobed may have taken effect. Requesters reissue after reset is released.
- Both reqs rising in the same IDLE cycle: LS wins.

## Test plan
- MEM_LAT=1, fetch `if_addr`=0x10 with memory word 0xDEADBEEF: `mem_en` high in cycle 1 with `mem_addr`=0x10, then `if_ack`=1 and `if_rdata`=0xDEADBEEF in cycle 2; `ls_ack` stays 0.
- MEM_LAT=1, `if_req` and `ls_req` (load 0x20) rise together: LS is acked in cycle 2; `mem_en` for 0x10 is in cycle 3; `if_ack` is in cycle 4; `busy` is high in cycles 1-4.
- MEM_LAT=3, store 0x55 to 0x40: `mem_we`=`mem_en`=1 in cycle 1 and `ls_ack` in cycle 2. A following load of 0x40 acks in cycle 4 after the load request (`ls_req` at cycle 0), returning `ls_rdata`=0x55.
- MEM_LAT=3, both reqs held continuously for 6 transactions: acks alternate LS, IF, LS, IF, LS, IF, spaced 4 cycles apart, with one `mem_en` per transaction.
- MEM_LAT=4, fetch issued, then `rst` asserted mid-WAIT: all outputs are 0 immediately, no `if_ack` follows, and after release a reissued fetch acks 5 cycles after its req.
- `if_addr` changed from 0x10 to 0x14 in cycle 1 of a fetch: `mem_addr` stays 0x10 and the ack returns the data at 0x10.
